config_segment_loader: RTL and testbench

CONFIG_SEGMENT_LOADER -- requirements
Module: config_segment_loader

---
 rtl/config_segment_loader_pkg.sv | 12 +
 rtl/config_segment_loader_cfg_shift_reg.sv | 38 +++
 rtl/config_segment_loader.sv | 100 ++++++++++
 tb/tb_config_segment_loader.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/config_segment_loader_pkg.sv
// Shared types and defaults for the configuration segment loader.
package config_segment_loader_pkg;

    localparam int DEFAULT_IN_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/config_segment_loader_cfg_shift_reg.sv
// Shadow shift register: words enter at the top and move down, so the first
// word ends up in the least-significant slice after a full load.
module cfg_shift_reg
    import config_segment_loader_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int IN_W  = DEFAULT_IN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic [IN_W-1:0]  din,
    output logic [NBITS-1:0] q
);

    logic [NBITS-1:0] q_q;

    // A single-word segment has nothing to shift down, so it needs its own form.
    generate
        if (NBITS == IN_W) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset)      q_q <= '0;
                else if (clear) q_q <= '0;
                else if (shift) q_q <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge reset) begin
                if (reset)      q_q <= '0;
                else if (clear) q_q <= '0;
                else if (shift) q_q <= {din, q_q[NBITS-1:IN_W]};
            end
        end
    endgenerate

    assign q = q_q;

endmodule

// File: rtl/config_segment_loader.sv
// Loads NBITS of switch-box configuration as IN_W-bit words into a shadow
// register and commits them to cfg atomically, so partial loads never reach the fabric.
module config_segment_loader
    import config_segment_loader_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int IN_W  = DEFAULT_IN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NBITS-1:0] cfg,
    output logic             cfg_valid,
    output logic             done,
    output logic             busy
);

    localparam int NWORDS = NBITS / IN_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] cfg_q;
    logic             cfg_valid_q;
    logic             done_q;
    logic [NBITS-1:0] shadow;
    logic             sh_clear, sh_shift, commit;

    cfg_shift_reg #(
        .NBITS (NBITS),
        .IN_W  (IN_W)
    ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .clear (sh_clear),
        .shift (sh_shift),
        .din   (in_data),
        .q     (shadow)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_clear = 1'b0;
        sh_shift = 1'b0;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    sh_clear = 1'b1;
                end
            end
            LOAD: begin
                // Abort beats a coincident accept, even on the final word.
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    sh_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) state_d = COMMIT;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            done_q      <= commit;
            cfg_valid_q <= cfg_valid_q | commit;
            if (commit) cfg_q <= shadow;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign cfg       = cfg_q;
    assign cfg_valid = cfg_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_config_segment_loader.sv
// Directed bench: expected commits go into a queue, a monitor compares on each done pulse.
module tb_config_segment_loader;

    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, cfg_valid, done, busy;
    logic [31:0] cfg;

    logic        start8, in_valid8;
    logic [7:0]  in_data8, cfg8, north, south;
    logic        in_ready8, cfg_valid8, done8, busy8;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    config_segment_loader #(.NBITS(32), .IN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cfg(cfg), .cfg_valid(cfg_valid), .done(done), .busy(busy)
    );

    config_segment_loader #(.NBITS(8), .IN_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .abort(1'b0),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .cfg(cfg8), .cfg_valid(cfg_valid8), .done(done8), .busy(busy8)
    );

    // Switch box: each closed switch (cfg8[k]=1) ties north[k] to south[k].
    always_comb begin
        for (int k = 0; k < 8; k++) south[k] = cfg8[k] ? north[k] : 1'b0;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Monitor: every done pulse must match the next queued commit.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", cfg, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("commit_cfg", cfg, e);
                check("commit_cfg_valid", {31'd0, cfg_valid}, 32'd1);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap, input logic ab);
        in_valid = 1'b0;
        repeat (gap) next_cycle();
        in_data  = w;
        in_valid = 1'b1;
        abort    = ab;
        next_cycle();
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        int sb_bad;
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        start8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0; north = '0;
        repeat (3) next_cycle();
        check("rst_cfg", cfg, 32'h0);
        check("rst_flags", {28'd0, cfg_valid, busy, in_ready, done}, 32'h0);
        reset = 1'b0;
        repeat (2) next_cycle();
        check("idle_flags", {28'd0, cfg_valid, busy, in_ready, done}, 32'h0);

        // Full load with in_valid held high.
        start_load(1'b0);
        check("load_ready_busy", {30'd0, busy, in_ready}, 32'h3);
        send_word(8'h11, 0, 1'b0);
        send_word(8'h22, 0, 1'b0);
        send_word(8'h33, 0, 1'b0);
        exp_q.push_back(32'h4433_2211);
        send_word(8'h44, 0, 1'b0);
        check("commit_state_flags", {30'd0, busy, in_ready}, 32'h2);
        check("cfg_held_before_commit", cfg, 32'h0);
        next_cycle();
        check("done_pulse_high", {31'd0, done}, 32'd1);
        next_cycle();
        check("done_pulse_low", {30'd0, done, busy}, 32'h0);

        // Gapped words, then abort on the third word.
        start_load(1'b0);
        send_word(8'hAA, 2, 1'b0);
        check("stall_ready", {30'd0, busy, in_ready}, 32'h3);
        send_word(8'hBB, 1, 1'b0);
        send_word(8'hCC, 0, 1'b1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cfg_kept", cfg, 32'h4433_2211);
        check("abort_cfg_valid", {31'd0, cfg_valid}, 32'd1);

        // start+abort in IDLE: start wins; abort coincident with last word.
        start_load(1'b1);
        check("start_wins", {31'd0, busy}, 32'd1);
        send_word(8'hE1, 0, 1'b0);
        send_word(8'hE2, 0, 1'b0);
        send_word(8'hE3, 0, 1'b0);
        send_word(8'hE4, 0, 1'b1);
        check("abort_last_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        check("abort_last_cfg", cfg, 32'h4433_2211);

        // Full load, then a back-to-back load started in the done cycle.
        start_load(1'b0);
        send_word(8'h01, 0, 1'b0);
        send_word(8'h02, 0, 1'b0);
        send_word(8'h03, 0, 1'b0);
        exp_q.push_back(32'h0403_0201);
        send_word(8'h04, 0, 1'b0);
        next_cycle();
        check("b2b_cfg", cfg, 32'h0403_0201);
        start_load(1'b0);
        check("b2b_started", {31'd0, busy}, 32'd1);
        send_word(8'hD0, 0, 1'b0);
        send_word(8'hC0, 1, 1'b0);
        send_word(8'hB0, 0, 1'b0);
        exp_q.push_back(32'hA0B0_C0D0);
        send_word(8'hA0, 3, 1'b0);
        repeat (2) next_cycle();
        check("b2b_cfg2", cfg, 32'hA0B0_C0D0);

        // Asynchronous reset between edges in the middle of a load.
        start_load(1'b0);
        send_word(8'h77, 0, 1'b0);
        send_word(8'h88, 0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_cfg", cfg, 32'h0);
        check("async_rst_flags", {28'd0, cfg_valid, busy, in_ready, done}, 32'h0);
        repeat (2) next_cycle();
        reset = 1'b0;
        repeat (5) next_cycle();
        check("post_rst_idle", {30'd0, busy, cfg_valid}, 32'h0);

        // Single-word loader driving the switch box.
        start8 = 1'b1;
        next_cycle();
        start8 = 1'b0;
        in_data8 = 8'h5A;
        in_valid8 = 1'b1;
        next_cycle();
        in_valid8 = 1'b0;
        next_cycle();
        check("sb_cfg", {23'd0, cfg_valid8, cfg8}, 32'h15A);
        sb_bad = 0;
        for (int c = 0; c < 100; c++) begin
            north = 8'($urandom);
            #1;
            for (int k = 0; k < 8; k++)
                if (cfg8[k] && (north[k] !== south[k])) sb_bad++;
            next_cycle();
        end
        check("sb_mismatches", 32'(sb_bad), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
